ece423_i2c_byte_master: RTL and testbench

//  Avalon-MM byte-level I2C master. Replaces CPU bit-banging of the SDA/SCL PIOs.

---
 rtl/ece423_i2c_byte_master.sv | 113 +++++++++++
 tb/tb_ece423_i2c_byte_master.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ece423_i2c_byte_master.sv
// ece423_i2c_byte_master: Avalon-MM byte-level I2C master driving open-drain SDA/SCL enables
module ece423_i2c_byte_master #(
  parameter logic [15:0] DIV_RESET = 16'd124
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        sda_in,
  input  logic        scl_in,
  output logic        sda_oe,
  output logic        scl_oe,
  output logic        irq
);
  localparam logic [1:0] ST_IDLE = 2'd0, ST_START = 2'd1, ST_BYTE = 2'd2, ST_STOP = 2'd3;
  logic [1:0] state, q, ns, en_s, en_q;
  logic [3:0] b, en_b;
  logic [15:0] clkdiv, div_act, cnt;
  logic [7:0] tx, rx;
  logic busy, done, rx_nack, bus_held;
  logic f_start, f_stop, f_wr, f_rd, f_nack;
  logic wr, cmd_acc, freeze, adv, last, launch, enter, bit_oe, n_sda, n_scl;
  logic unused_bits;
  assign wr = chipselect & ~write_n;
  assign cmd_acc = wr && address == 2'd1 && !busy;
  assign irq = done;
  assign unused_bits = ^writedata[31:16];
  // Quarter sequencing: stretch freeze, stage chaining and the line levels for the quarter being entered
  always_comb begin
    freeze = ~scl_in & ~scl_oe & ((state == ST_BYTE && (q == 2'd1 || q == 2'd2)) || (state == ST_STOP && q == 2'd1));
    adv = state != ST_IDLE && cnt == 16'd0 && !freeze;
    last = adv && q == 2'd3 && (state != ST_BYTE || b == 4'd8);
    launch = (state == ST_IDLE && busy) || last;
    ns = (state == ST_IDLE && f_start) ? ST_START :
         ((state == ST_IDLE || state == ST_START) && (f_wr || f_rd)) ? ST_BYTE :
         (state != ST_STOP && f_stop) ? ST_STOP : ST_IDLE;
    enter = launch ? ns != ST_IDLE : adv;
    en_s = launch ? ns : state;
    en_q = launch ? 2'd0 : q + 2'd1;
    en_b = launch ? 4'd0 : q == 2'd3 ? b + 4'd1 : b;
    bit_oe = en_b == 4'd8 ? ~f_wr & ~f_nack : f_wr & ~tx[3'd7 - en_b[2:0]];
    n_scl = en_s == ST_START ? (en_q == 2'd0 ? 1'b0 : en_q == 2'd2 ? 1'b1 : scl_oe) :
            en_s == ST_BYTE  ? (en_q == 2'd1 ? 1'b0 : en_q == 2'd2 ? scl_oe : 1'b1) :
                               (en_q == 2'd0 ? 1'b1 : en_q == 2'd1 ? 1'b0 : scl_oe);
    n_sda = en_s == ST_START ? (en_q == 2'd0 ? 1'b0 : en_q == 2'd1 ? 1'b1 : sda_oe) :
            en_s == ST_BYTE  ? (en_q == 2'd0 ? bit_oe : sda_oe) :
                               (en_q == 2'd0 ? 1'b1 : en_q == 2'd2 ? 1'b0 : sda_oe);
  end
  // Register file, command acceptance, quarter counter, line drivers and bit sampling
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
      sda_oe <= 1'b0;
      scl_oe <= 1'b0;
      tx <= '0;
      rx <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      rx_nack <= 1'b0;
      bus_held <= 1'b0;
      f_start <= 1'b0;
      f_stop <= 1'b0;
      f_wr <= 1'b0;
      f_rd <= 1'b0;
      f_nack <= 1'b0;
      clkdiv <= DIV_RESET;
      div_act <= DIV_RESET;
      cnt <= '0;
      state <= ST_IDLE;
      q <= '0;
      b <= '0;
    end else begin
      readdata <= address == 2'd0 ? {24'd0, rx} :
                  address == 2'd2 ? {28'd0, bus_held, done, rx_nack, busy} :
                  address == 2'd3 ? {16'd0, clkdiv} : 32'd0;
      if (wr && address == 2'd0) tx <= writedata[7:0];
      if (wr && address == 2'd3) clkdiv <= writedata[15:0];
      if (wr && address == 2'd2 && writedata[2]) done <= 1'b0;
      if (cmd_acc) begin
        busy <= 1'b1;
        done <= 1'b0;
        f_start <= writedata[0];
        f_stop <= writedata[1];
        f_wr <= writedata[2];
        f_rd <= writedata[3] & ~writedata[2];
        f_nack <= writedata[4];
        div_act <= clkdiv;
      end
      if (launch && ns == ST_IDLE) begin
        busy <= 1'b0;
        done <= 1'b1;
        state <= ST_IDLE;
      end
      if (enter) begin
        state <= en_s;
        q <= en_q;
        b <= en_b;
        cnt <= div_act;
        sda_oe <= n_sda;
        scl_oe <= n_scl;
      end else if (state != ST_IDLE && !freeze && cnt != 16'd0) cnt <= cnt - 16'd1;
      if (enter && en_s == ST_START && en_q == 2'd0) bus_held <= 1'b1;
      if (last && state == ST_STOP) bus_held <= 1'b0;
      if (adv && state == ST_BYTE && q == 2'd2) begin
        if (b == 4'd8) rx_nack <= f_wr ? sda_in : rx_nack;
        else if (f_rd) rx <= {rx[6:0], sda_in};
      end
    end
  end
endmodule

// File: tb/tb_ece423_i2c_byte_master.sv
// tb_ece423_i2c_byte_master: directed and random commands against a bus-level I2C slave and transaction model
module tb_ece423_i2c_byte_master;
  logic clk = 1'b0, reset = 1'b1, chipselect = 1'b0, write_n = 1'b1, stretch = 1'b0, slave_rel = 1'b1;
  logic [1:0] address = 2'd0;
  logic [31:0] writedata = 32'd0, readdata;
  logic sda_oe, scl_oe, irq, sda_in, scl_in;
  int nvec = 0, nerr = 0, cyc = 0, t_acc = 0;
  logic slave_q[$];
  logic psda = 1'b1, pscl = 1'b1;
  logic [31:0] cap_bits = 32'd0;
  int cap_n = 0, n_start = 0, n_stop = 0;
  logic [15:0] m_div = 16'd124;
  logic [7:0] m_tx = 8'd0, m_rx = 8'd0;
  logic m_rxn = 1'b0, m_held = 1'b0;
  logic [31:0] e_bits;
  int e_n, e_cyc, e_start, e_stop, b_n, b_start, b_stop;

  assign sda_in = ~sda_oe & slave_rel;
  assign scl_in = ~scl_oe & ~stretch;

  ece423_i2c_byte_master dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata), .sda_in(sda_in), .scl_in(scl_in),
    .sda_oe(sda_oe), .scl_oe(scl_oe), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor and slave: SDA captured on SCL rise, START/STOP detected, slave shifts its next level on SCL fall
  always @(negedge clk) begin
    if (!pscl && scl_in) begin
      cap_bits = {cap_bits[30:0], sda_in};
      cap_n++;
    end
    if (pscl && scl_in && psda && !sda_in) n_start++;
    if (pscl && scl_in && !psda && sda_in) n_stop++;
    psda = sda_in;
    if (reset) begin
      slave_q.delete();
      slave_rel = 1'b1;
    end else if (pscl && !scl_in) slave_rel = slave_q.size() > 0 ? slave_q.pop_front() : 1'b1;
    pscl = scl_in;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    tick();
    d = readdata;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outcome of one command from the protocol rules: quarters, bits on the wire, status
  task automatic prep(input logic [4:0] c, input logic [7:0] sb, input logic ack);
    logic w, r;
    int nq;
    w = c[2];
    r = c[3] & ~c[2];
    nq = 4 * int'(c[0]) + 36 * int'(w | r) + 4 * int'(c[1]);
    e_cyc = 1 + nq * (int'(m_div) + 1);
    e_bits = 32'd0;
    e_n = 0;
    if (w | r) begin
      for (int i = 7; i >= 0; i--) begin
        e_bits = {e_bits[30:0], w ? m_tx[i] : sb[i]};
        slave_q.push_back(w ? 1'b1 : sb[i]);
      end
      e_bits = {e_bits[30:0], w ? ~ack : c[4]};
      slave_q.push_back(w ? ~ack : 1'b1);
      e_n = 9;
    end
    if (c[1]) begin
      e_bits = {e_bits[30:0], 1'b0};
      e_n++;
    end
    if (w) m_rxn = ~ack;
    if (r) m_rx = sb;
    if (c[0]) m_held = 1'b1;
    if (c[1]) m_held = 1'b0;
    e_start = int'(c[0]);
    e_stop = int'(c[1]);
    b_n = cap_n;
    b_start = n_start;
    b_stop = n_stop;
  endtask

  task automatic launch(input logic [4:0] c);
    wr(2'd1, {27'd0, c});
    t_acc = cyc;
  endtask

  task automatic wait_done(output int k);
    while (!irq && cyc - t_acc < 20000) tick();
    k = cyc - t_acc;
  endtask

  task automatic check(input int k);
    logic [31:0] d, mask;
    mask = (32'd1 << e_n) - 32'd1;
    chk("irq_done", {31'd0, irq}, 32'd1);
    chk("busy_cycles", k, e_cyc);
    chk("sda_on_scl_rise", cap_bits & mask, e_bits);
    chk("scl_pulses", cap_n - b_n, e_n);
    chk("start_conditions", n_start - b_start, e_start);
    chk("stop_conditions", n_stop - b_stop, e_stop);
    rd(2'd2, d);
    chk("status", d, {28'd0, m_held, 1'b1, m_rxn, 1'b0});
    rd(2'd0, d);
    chk("data_rx", d, {24'd0, m_rx});
  endtask

  task automatic run(input logic [4:0] c, input logic [7:0] sb, input logic ack);
    int k;
    prep(c, sb, ack);
    launch(c);
    wait_done(k);
    check(k);
  endtask

  initial begin
    logic [31:0] d;
    int k, n, bn;
    repeat (3) tick();
    chk("reset_readdata", readdata, 32'd0);
    chk("reset_lines", {30'd0, sda_oe, scl_oe}, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    rd(2'd2, d); chk("reset_status", d, 32'd0);
    rd(2'd3, d); chk("reset_clkdiv", d, 32'd124);
    rd(2'd0, d); chk("reset_data", d, 32'd0);

    wr(2'd3, 32'd3); m_div = 16'd3;
    rd(2'd3, d); chk("clkdiv_rw", d, 32'd3);
    wr(2'd0, 32'hA5); m_tx = 8'hA5;
    run(5'h07, 8'h00, 1'b1);

    run(5'h19, 8'h3C, 1'b1);

    wr(2'd0, 32'h96); m_tx = 8'h96;
    run(5'h04, 8'h00, 1'b0);
    run(5'h02, 8'h00, 1'b1);

    wr(2'd2, 32'h4);
    chk("done_clear_irq", {31'd0, irq}, 32'd0);
    rd(2'd2, d); chk("done_clear_status", d, {28'd0, m_held, 1'b0, m_rxn, 1'b0});

    run(5'h00, 8'h00, 1'b1);
    run(5'h10, 8'h00, 1'b1);

    wr(2'd0, 32'h5B); m_tx = 8'h5B;
    prep(5'h07, 8'h00, 1'b1);
    e_cyc += 50;
    launch(5'h07);
    n = 0;
    while (!(cap_n - b_n >= 3 && scl_oe) && n < 5000) begin tick(); n++; end
    stretch = 1'b1;
    n = 0;
    while (scl_oe && n < 5000) begin tick(); n++; end
    repeat (50) @(posedge clk);
    #1 stretch = 1'b0;
    wait_done(k);
    check(k);

    wr(2'd0, 32'hC3); m_tx = 8'hC3;
    prep(5'h07, 8'h00, 1'b1);
    launch(5'h07);
    repeat (20) tick();
    wr(2'd1, 32'h0B);
    wait_done(k);
    check(k);

    for (int i = 0; i < 10; i++) begin
      logic [4:0] c;
      logic [15:0] dv;
      logic [7:0] t;
      dv = 16'($urandom_range(1, 4));
      wr(2'd3, {16'd0, dv}); m_div = dv;
      t = 8'($urandom);
      wr(2'd0, {24'd0, t}); m_tx = t;
      c = 5'($urandom);
      run(c, 8'($urandom), 1'($urandom));
      if (!c[1] && (c[0] || c[2] || c[3])) run(5'h02, 8'h00, 1'b1);
    end

    wr(2'd0, 32'h69);
    bn = cap_n;
    launch(5'h07);
    n = 0;
    while (cap_n - bn < 6 && n < 5000) begin tick(); n++; end
    chk("reached_bit5", {31'd0, cap_n - bn >= 6}, 32'd1);
    reset = 1'b1;
    tick();
    chk("midreset_lines", {30'd0, sda_oe, scl_oe}, 32'd0);
    chk("midreset_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    m_div = 16'd124; m_tx = 8'd0; m_rx = 8'd0; m_rxn = 1'b0; m_held = 1'b0;
    rd(2'd2, d); chk("midreset_status", d, 32'd0);
    rd(2'd3, d); chk("midreset_clkdiv", d, 32'd124);
    run(5'h07, 8'h00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
